branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised branch prediction + resolution unit. Fetch side: bimodal predictor
//  (2-bit saturating counters) with a direct-mapped BTB, looked up on fetch PC.
//  Execute side: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR from ALU flags, flags mispredicts,
//  supplies redirect PC, trains tables. Sits between IF (lookup) and EX (resolve/update).
// PARAMETERS
//  XLEN      32     address/target width
//  ENTRIES   16     BTB/counter entries; power of 2, >=2; IDX_W=$clog2(ENTRIES)
//  CTR_INIT  2'b01  counter reset value (weakly not-taken)
//  PERF_W    32     width of performance counters
// PORTS
//  clk_i             in   1      clock, rising edge
//  rst_ni            in   1      asynchronous active-low reset
//  fetch_pc_i        in   XLEN   PC being fetched
//  pred_taken_o      out  1      predicted taken for fetch_pc_i
//  pred_target_o     out  XLEN   predicted target (valid when pred_taken_o)
//  ex_valid_i        in   1      EX-stage instruction valid this cycle
//  ex_pc_i           in   XLEN   PC of EX instruction
//  is_branch_i / is_jal_i / is_jalr_i  in  1 each  decoded control type (one-hot or none)
//  funct3_i          in   3      branch condition
//  zero_flag_i / negative_flag_i / overflow_flag_i / carry_flag_i  in  1 each  flags of rs1-rs2
//  ex_target_i       in   XLEN   computed target of EX instruction
//  ex_pred_taken_i   in   1      prediction carried down pipe with EX instr
//  ex_pred_target_i  in   XLEN   predicted target carried down pipe
//  take_branch_o     out  1      resolved taken
//  mispredict_o      out  1      flush + redirect request
//  redirect_pc_o     out  XLEN   correct next PC when mispredict_o
//  branch_cnt_o      out  PERF_W resolved control instrs (BP_PERF_CNT_EN)
//  mispredict_cnt_o  out  PERF_W mispredicts (BP_PERF_CNT_EN)
// BEHAVIOUR
//  - idx=pc[IDX_W+1:2]; tag=pc[XLEN-1:IDX_W+2]. Entry: valid, tag, target, jump bit, ctr[1:0].
//  - Lookup combinational: hit=valid&&tag match; pred_taken_o=hit&&(jump||ctr[1]); pred_target_o=target[idx].
//  - Resolve combinational: slt=N^V; sltu=~C (C=carry of rs1+~rs2+1). JAL/JALR taken.
//    funct3 000 Z,001 ~Z,100 slt,101 ~slt,110 sltu,111 ~sltu; 010/011 not taken.
//  - ctrl=ex_valid_i&&(is_branch_i|is_jal_i|is_jalr_i); take_branch_o=0 when !ctrl.
//  - mispredict_o=ex_valid_i&&((ex_pred_taken_i!=take)||(take&&ex_pred_target_i!=ex_target_i)).
//    redirect_pc_o=take?ex_target_i:ex_pc_i+4 (mod 2^XLEN wrap). 0 when !mispredict_o.
//  - Update at clock edge (tables registered; visible to lookup next cycle, no same-cycle bypass):
//    ctrl&&take: write valid=1,tag,target,jump=(jal|jalr); ctr=hit?sat_inc(ctr):2'b10.
//    ctrl&&!take&&hit: ctr=sat_dec(ctr); miss: no write.
//    ex_valid_i&&!ctrl&&ex_pred_taken_i (alias): clear valid of matching entry.
//  - Saturation: 11 stays 11 on taken, 00 stays 00 on not-taken.
//  - Same-index lookup and update in one cycle: lookup returns pre-update contents.
//  - Reset (async, any time incl. mid-update): all valid=0, ctr=CTR_INIT, targets/tags 0;
//    all outputs 0 while rst_ni low; pending update discarded.
// CONFIGURATION
//  BP_PERF_CNT_EN defined: branch_cnt_o +1 per ctrl cycle, mispredict_cnt_o +1 per mispredict_o;
//    reset 0, wrap at 2^PERF_W. Undefined: counters not built, both ports tied 0.
// TESTING
//  1 reset, fetch_pc_i=0x100 -> pred_taken_o=0; ex BEQ Z=1 pred 0 -> take=1, mispredict, redirect=ex_target.
//  2 BNE @0x200 Z=0, target 0x180, x3 -> after 1st: pred taken 0x180, ctr 10->11->11; then Z=1 -> ctr 10.
//  3 BLTU N=0,C=0 -> taken; BGE N=1,V=1 -> taken; BLT N=1,V=0 -> taken; funct3=010 -> not taken.
//  4 JALR @0x300 pred target 0x400, actual 0x500 -> mispredict, redirect 0x500, BTB target updated.
//  5 ADD with ex_pred_taken_i=1 @0x240 -> mispredict, redirect 0x244, entry invalidated.
//  6 rst_ni low mid-update -> update lost, counters=CTR_INIT, perf counters=0 (BP_PERF_CNT_EN).

Source files
------------

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with a direct-mapped BTB, plus EX-stage branch resolution and table training.
// Optional feature macro: BP_PERF_CNT_EN builds the resolved-branch and mispredict performance counters.
module branch_predict_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   fetch_pc_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              ex_valid_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic              is_branch_i,
  input  logic              is_jal_i,
  input  logic              is_jalr_i,
  input  logic [2:0]        funct3_i,
  input  logic              zero_flag_i,
  input  logic              negative_flag_i,
  input  logic              overflow_flag_i,
  input  logic              carry_flag_i,
  input  logic [XLEN-1:0]   ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic [XLEN-1:0]   ex_pred_target_i,
  output logic              take_branch_o,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [PERF_W-1:0] branch_cnt_o,
  output logic [PERF_W-1:0] mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Instruction alignment means the two low PC bits never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc_i[1:0], ex_pc_i[1:0]};

  // Fetch-side lookup reads registered state only, so an update in the same
  // cycle is seen by the following lookup, never the current one.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = fetch_pc_i[XLEN-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign pred_taken_o  = rst_ni && f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
  assign pred_target_o = rst_ni ? tgt_q[f_idx] : '0;

  logic            slt;
  logic            sltu;
  logic            br_cond;
  logic            ctrl;
  logic            take;
  logic            mispredict;
  logic [XLEN-1:0] fallthrough_pc;

  assign slt  = negative_flag_i ^ overflow_flag_i;
  assign sltu = ~carry_flag_i;

  always_comb begin
    br_cond = 1'b0;
    case (funct3_i)
      3'b000:  br_cond = zero_flag_i;
      3'b001:  br_cond = ~zero_flag_i;
      3'b100:  br_cond = slt;
      3'b101:  br_cond = ~slt;
      3'b110:  br_cond = sltu;
      3'b111:  br_cond = ~sltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign ctrl = ex_valid_i && (is_branch_i || is_jal_i || is_jalr_i);
  assign take = ctrl && (is_jal_i || is_jalr_i || (is_branch_i && br_cond));

  // A non-control instruction predicted taken (BTB alias) also mispredicts,
  // since take is 0 for it; redirect then falls through to pc+4.
  assign mispredict = ex_valid_i &&
                      ((ex_pred_taken_i != take) ||
                       (take && (ex_pred_target_i != ex_target_i)));
  assign fallthrough_pc = ex_pc_i + XLEN'(4);

  assign take_branch_o = rst_ni && take;
  assign mispredict_o  = rst_ni && mispredict;
  assign redirect_pc_o = (rst_ni && mispredict) ? (take ? ex_target_i : fallthrough_pc) : '0;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd_take;
  logic             upd_dec;
  logic             upd_inv;

  assign ex_idx   = ex_pc_i[IDX_W+1:2];
  assign ex_tag   = ex_pc_i[XLEN-1:IDX_W+2];
  assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd_take = ctrl && take;
  assign upd_dec  = ctrl && !take && ex_hit;
  assign upd_inv  = ex_valid_i && !ctrl && ex_pred_taken_i && ex_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      if (upd_take) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= ex_target_i;
        jump_q[ex_idx]  <= is_jal_i || is_jalr_i;
        ctr_q[ex_idx]   <= ex_hit ? sat_inc(ctr_q[ex_idx]) : 2'b10;
      end else if (upd_dec) begin
        ctr_q[ex_idx]   <= sat_dec(ctr_q[ex_idx]);
      end else if (upd_inv) begin
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [PERF_W-1:0] br_cnt_q;
  logic [PERF_W-1:0] mp_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (ctrl)       br_cnt_q <= br_cnt_q + PERF_W'(1);
      if (mispredict) mp_cnt_q <= mp_cnt_q + PERF_W'(1);
    end
  end

  assign branch_cnt_o     = br_cnt_q;
  assign mispredict_cnt_o = mp_cnt_q;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: the driver pushes hand-computed expectations, the monitor checks them.
module tb_branch_predict_unit;

  localparam logic [2:0] BR = 3'b100;
  localparam logic [2:0] JL = 3'b010;
  localparam logic [2:0] JR = 3'b001;
  localparam logic [2:0] NO = 3'b000;
  localparam logic [4:0] M_ALL = 5'h1F;
  localparam logic [4:0] M_EX  = 5'h1C;
  localparam logic [4:0] M_F   = 5'h03;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        zf = 1'b0, nf = 1'b0, vf = 1'b0, cf = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        take_branch;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  branch_predict_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_pc_i(fetch_pc), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc),
    .is_branch_i(is_branch), .is_jal_i(is_jal), .is_jalr_i(is_jalr),
    .funct3_i(funct3),
    .zero_flag_i(zf), .negative_flag_i(nf), .overflow_flag_i(vf), .carry_flag_i(cf),
    .ex_target_i(ex_target), .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target),
    .take_branch_o(take_branch), .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
    .branch_cnt_o(branch_cnt), .mispredict_cnt_o(mispredict_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [4:0]  m;
    logic        pt;
    logic [31:0] ptg;
    logic        tk;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  step_id = '0;
  logic [31:0] m_br = '0;
  logic [31:0] m_mp = '0;

  task automatic check(input string nm, input logic [7:0] id, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%08h required=0x%08h", nm, id, act, expv);
    end
  endtask

  // Driver: inputs change 1 time unit after the rising edge; valid for the next edge.
  task automatic step(input logic [31:0] fpc, input logic v, input logic [2:0] typ,
                      input logic [2:0] f3, input logic [3:0] fl, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic ptk, input logic [31:0] ptg,
                      input logic [4:0] m, input logic e_pt, input logic [31:0] e_ptg,
                      input logic e_tk, input logic e_mp, input logic [31:0] e_rd);
    exp_t e;
    @(posedge clk); #1;
    fetch_pc = fpc; ex_valid = v;
    {is_branch, is_jal, is_jalr} = typ;
    funct3 = f3; {zf, nf, vf, cf} = fl;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptg;
    e.id = step_id; e.m = m; e.pt = e_pt; e.ptg = e_ptg; e.tk = e_tk; e.mp = e_mp; e.rd = e_rd;
`ifdef BP_PERF_CNT_EN
    e.bc = m_br; e.mc = m_mp;
`else
    e.bc = '0; e.mc = '0;
`endif
    exp_q.push_back(e);
    if (rst_n && v && (typ != NO)) m_br++;
    if (rst_n && e_mp) m_mp++;
    step_id++;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; {is_branch, is_jal, is_jalr} = NO; ex_pred_taken = 1'b0;
  endtask

  // Scoreboard monitor: outputs are combinational, so sample mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (cur.m[0]) check("pred_taken",  cur.id, {31'b0, pred_taken},  {31'b0, cur.pt});
        if (cur.m[1]) check("pred_target", cur.id, pred_target,          cur.ptg);
        if (cur.m[2]) check("take_branch", cur.id, {31'b0, take_branch}, {31'b0, cur.tk});
        if (cur.m[3]) check("mispredict",  cur.id, {31'b0, mispredict},  {31'b0, cur.mp});
        if (cur.m[4]) check("redirect_pc", cur.id, redirect_pc,          cur.rd);
        check("branch_cnt",     cur.id, branch_cnt,     cur.bc);
        check("mispredict_cnt", cur.id, mispredict_cnt, cur.mc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d actual=timeout required=finish", step_id);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held: outputs must be zero even with a taken branch on the inputs.
    step(32'h100, 1, BR, 3'b000, 4'b1000, 32'h100, 32'h140, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    idle_ex();
    @(negedge clk); rst_n = 1'b1;

    // BEQ taken, cold tables; same-index lookup sees pre-update contents.
    step(32'h100, 1, BR, 3'b000, 4'b1000, 32'h100, 32'h140, 0, 0, M_ALL, 0, 0, 1, 1, 32'h140);
    step(32'h100, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_ALL, 1, 32'h140, 0, 0, 0);
    // BNE @0x208: miss->10, 11, 11(sat), then not-taken 10, 01, 00, 00(sat), taken 01.
    step(32'h208, 1, BR, 3'b001, 4'b0000, 32'h208, 32'h180, 0, 0, M_ALL, 0, 0, 1, 1, 32'h180);
    step(32'h208, 1, BR, 3'b001, 4'b0000, 32'h208, 32'h180, 1, 32'h180, M_ALL, 1, 32'h180, 1, 0, 0);
    step(32'h208, 1, BR, 3'b001, 4'b0000, 32'h208, 32'h180, 1, 32'h180, M_ALL, 1, 32'h180, 1, 0, 0);
    step(32'h208, 1, BR, 3'b001, 4'b1000, 32'h208, 32'h180, 1, 32'h180, M_ALL, 1, 32'h180, 0, 1, 32'h20C);
    step(32'h208, 1, BR, 3'b001, 4'b1000, 32'h208, 32'h180, 1, 32'h180, M_ALL, 1, 32'h180, 0, 1, 32'h20C);
    step(32'h208, 1, BR, 3'b001, 4'b1000, 32'h208, 32'h180, 0, 0, M_ALL, 0, 32'h180, 0, 0, 0);
    step(32'h208, 1, BR, 3'b001, 4'b1000, 32'h208, 32'h180, 0, 0, M_ALL, 0, 32'h180, 0, 0, 0);
    step(32'h208, 1, BR, 3'b001, 4'b0000, 32'h208, 32'h180, 0, 0, M_ALL, 0, 32'h180, 1, 1, 32'h180);
    step(32'h208, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_ALL, 0, 32'h180, 0, 0, 0);

    // Condition decode; flags are {Z,N,V,C}.
    step(32'h1000, 1, BR, 3'b110, 4'b0000, 32'h010, 32'h800, 0, 0, M_EX, 0, 0, 1, 1, 32'h800);
    step(32'h1000, 1, BR, 3'b101, 4'b0110, 32'h014, 32'h804, 0, 0, M_EX, 0, 0, 1, 1, 32'h804);
    step(32'h1000, 1, BR, 3'b100, 4'b0100, 32'h018, 32'h808, 0, 0, M_EX, 0, 0, 1, 1, 32'h808);
    step(32'h1000, 1, BR, 3'b010, 4'b1000, 32'h020, 32'h80C, 0, 0, M_EX, 0, 0, 0, 0, 0);
    step(32'h1000, 1, BR, 3'b011, 4'b1111, 32'h020, 32'h80C, 0, 0, M_EX, 0, 0, 0, 0, 0);
    step(32'h1000, 1, BR, 3'b000, 4'b0000, 32'h020, 32'h80C, 0, 0, M_EX, 0, 0, 0, 0, 0);
    step(32'h1000, 1, BR, 3'b111, 4'b0000, 32'h020, 32'h80C, 0, 0, M_EX, 0, 0, 0, 0, 0);
    step(32'h1000, 1, BR, 3'b111, 4'b0001, 32'h024, 32'h810, 1, 32'h810, M_EX, 0, 0, 1, 0, 0);
    step(32'h1000, 1, BR, 3'b110, 4'b0001, 32'h020, 32'h80C, 0, 0, M_EX, 0, 0, 0, 0, 0);
    step(32'h1000, 1, BR, 3'b100, 4'b0110, 32'h020, 32'h80C, 1, 32'h808, M_EX, 0, 0, 0, 1, 32'h024);
    step(32'h1000, 1, BR, 3'b101, 4'b0100, 32'h020, 32'h80C, 0, 0, M_EX, 0, 0, 0, 0, 0);
    step(32'h1000, 0, BR, 3'b000, 4'b1000, 32'h020, 32'h80C, 1, 32'h80C, M_EX, 0, 0, 0, 0, 0);
    step(32'h1000, 1, BR, 3'b001, 4'b1000, 32'hFFFF_FFFC, 32'h0, 1, 32'h0, M_EX, 0, 0, 0, 1, 32'h0);
    step(32'h1000, 1, BR, 3'b000, 4'b1000, 32'h020, 32'h80C, 1, 32'h700, M_EX, 0, 0, 1, 1, 32'h80C);

    // JALR target change updates the BTB; JAL with correct prediction.
    step(32'h330, 1, JR, 3'b000, 4'b0000, 32'h330, 32'h400, 0, 0, M_ALL, 0, 0, 1, 1, 32'h400);
    step(32'h330, 1, JR, 3'b000, 4'b0000, 32'h330, 32'h500, 1, 32'h400, M_ALL, 1, 32'h400, 1, 1, 32'h500);
    step(32'h330, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_F, 1, 32'h500, 0, 0, 0);
    step(32'h000, 1, JL, 3'b000, 4'b0000, 32'h334, 32'h600, 1, 32'h600, M_EX, 0, 0, 1, 0, 0);

    // Alias: non-control instruction predicted taken invalidates its entry.
    step(32'h244, 1, BR, 3'b000, 4'b1000, 32'h244, 32'h260, 0, 0, M_ALL, 0, 0, 1, 1, 32'h260);
    step(32'h144, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_ALL, 0, 32'h260, 0, 0, 0);
    step(32'h244, 1, NO, 3'b000, 4'b0000, 32'h244, 32'h0, 1, 32'h260, M_ALL, 1, 32'h260, 0, 1, 32'h248);
    step(32'h244, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_ALL, 0, 32'h260, 0, 0, 0);

    // Reset lands before the edge that would commit this update.
    step(32'h208, 1, BR, 3'b000, 4'b1000, 32'h050, 32'h900, 0, 0, M_ALL, 0, 32'h180, 1, 1, 32'h900);
    @(negedge clk); #1;
    rst_n = 1'b0; m_br = '0; m_mp = '0;
    step(32'h050, 1, BR, 3'b000, 4'b1000, 32'h050, 32'h900, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    idle_ex();
    @(negedge clk); rst_n = 1'b1;
    step(32'h050, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step(32'h208, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);
    step(32'h100, 0, NO, 3'b000, 4'b0000, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
